imem_loader: RTL and testbench

//  Byte-stream program loader that writes the instruction memory the single-cycle CPU fetches from.
//  - Receives a framed byte stream over a valid/ready handshake.
//  - Assembles little-endian 32-bit instruction words and writes them sequentially from word address 0.
//  - Holds the CPU in reset until the full program is written, then releases it and flags done.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Framed byte-stream loader that writes little-endian 32-bit
//               words into instruction memory and holds the CPU in reset
//               until the whole program has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  load_req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    localparam logic [16:0] DEPTH_L = 17'(2 ** ADDR_WIDTH);

    localparam logic [2:0] S_HDR0  = 3'd0;
    localparam logic [2:0] S_HDR1  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]            state_q,    state_d;
    logic [15:0]           n_q,        n_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           word_q,     word_d;
    logic [ADDR_WIDTH-1:0] waddr_q,    waddr_d;
    logic [31:0]           wdata_q,    wdata_d;

    logic                  accept;
    logic [15:0]           n_full;
    logic                  last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR0;
            n_q        <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        accept     = in_valid && in_ready;
        n_full     = {in_data, n_q[7:0]};
        last_word  = ({1'b0, n_q} == (17'(word_cnt_q) + 17'd1));

        case (state_q)
            S_HDR0: begin
                if (accept) begin
                    n_d[7:0] = in_data;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    n_d[15:8]  = in_data;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    if (n_full == 16'd0 || {1'b0, n_full} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Capture the write port on the 4th byte so it is stable for the whole WRITE cycle.
                    if (byte_cnt_q == 2'd3) begin
                        waddr_d = word_cnt_q;
                        wdata_d = {in_data, word_q[23:0]};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                state_d    = last_word ? S_DONE : S_DATA;
            end
            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d    = S_HDR0;
                    n_d        = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
                end
            end
            default: state_d = S_HDR0;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        imem_we  = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
            S_WRITE:                imem_we  = 1'b1;
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR:                  err      = 1'b1;
            default: ;
        endcase
    end

    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed vector table plus streamed-frame sequences for
//               imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        load_req;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // exp packs {in_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, done, err}
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        lr;
        logic        rs;
        logic [44:0] exp;
    } vec_t;

    vec_t        vq[$];
    logic [7:0]  h_addr;
    logic [31:0] h_data;
    int          n_assert = 0;
    int          n_fail   = 0;

    logic [7:0]  sq[$];
    logic [31:0] ew[$];
    logic [7:0]  wq_a[$];
    logic [31:0] wq_d[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void row(input logic v, input logic [7:0] d, input logic lr, input logic rs,
                                input logic rdy, input logic we, input logic [7:0] a,
                                input logic [31:0] w, input logic crst, input logic dn,
                                input logic er);
        vec_t r;
        r.v   = v;
        r.d   = d;
        r.lr  = lr;
        r.rs  = rs;
        r.exp = {rdy, we, a, w, crst, dn, er};
        vq.push_back(r);
    endfunction

    function automatic void hdr(input logic [15:0] n);
        row(1, n[7:0],  0, 0, 1, 0, h_addr, h_data, 1, 0, 0);
        row(1, n[15:8], 0, 0, 1, 0, h_addr, h_data, 1, 0, 0);
    endfunction

    function automatic void word(input logic [31:0] w, input logic [7:0] a);
        for (int b = 0; b < 4; b++) begin
            row(1, w[8*b +: 8], 0, 0, 1, 0, h_addr, h_data, 1, 0, 0);
        end
        // byte offered during WRITE must be ignored
        row(1, 8'hAA, 0, 0, 0, 1, a, w, 1, 0, 0);
        h_addr = a;
        h_data = w;
    endfunction

    function automatic void done_row(input logic v, input logic lr);
        row(v, 8'h55, lr, 0, 0, 0, h_addr, h_data, 0, 1, 0);
    endfunction

    function automatic void err_row(input logic v, input logic lr, input logic rs);
        row(v, 8'h66, lr, rs, 0, 0, h_addr, h_data, 1, 0, 1);
    endfunction

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq_a.push_back(imem_waddr);
            wq_d.push_back(imem_wdata);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        load_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic build_frame();
        sq.delete();
        sq.push_back(8'(ew.size()));
        sq.push_back(8'(ew.size() >> 8));
        foreach (ew[k]) begin
            for (int b = 0; b < 4; b++) sq.push_back(ew[k][8*b +: 8]);
        end
    endtask

    task automatic stream(input bit gaps);
        int i     = 0;
        int guard = 0;
        int gap   = 0;
        while (i < sq.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (gaps && gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else begin
                in_valid = 1'b1;
                in_data  = sq[i];
                #1;
                check("ready_vs_write", {63'd0, in_ready}, {63'd0, ~imem_we});
                if (in_ready) begin
                    i++;
                    gap = gaps ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
        if (guard >= 20000) begin
            n_assert++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d bytes expected %0d", i, sq.size());
        end
        // cycle after the final byte: WRITE, then DONE
        @(negedge clk);
        in_valid = 1'b0;
        check("last_we",       {63'd0, imem_we}, 64'd1);
        check("last_cpu_rst",  {63'd0, cpu_rst}, 64'd1);
        @(negedge clk);
        check("end_done",      {63'd0, done},    64'd1);
        check("end_cpu_rst",   {63'd0, cpu_rst}, 64'd0);
        check("end_ready",     {63'd0, in_ready}, 64'd0);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 64'(wq_a.size()), 64'(ew.size()));
        for (int k = 0; k < ew.size() && k < wq_a.size(); k++) begin
            check($sformatf("%s_addr[%0d]", tag, k), 64'(wq_a[k]), 64'(k));
            check($sformatf("%s_data[%0d]", tag, k), 64'(wq_d[k]), 64'(ew[k]));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        load_req = 1'b0;
        h_addr   = 8'h00;
        h_data   = 32'h0;

        // N=3 back-to-back program, then DONE
        hdr(16'd3);
        word(32'h00F00093, 8'd0);
        word(32'h01900113, 8'd1);
        word(32'h002081B3, 8'd2);
        done_row(0, 0);
        done_row(1, 0);
        // reload N=2 from DONE
        done_row(0, 1);
        hdr(16'd2);
        word(32'hCAFEF00D, 8'd0);
        word(32'h01234567, 8'd1);
        done_row(0, 0);
        // bad headers: N=0 and N=257
        done_row(0, 1);
        hdr(16'd0);
        err_row(1, 0, 0);
        err_row(1, 0, 0);
        err_row(0, 1, 0);
        hdr(16'd257);
        err_row(1, 0, 0);
        err_row(0, 0, 1);
        h_addr = 8'h00;
        h_data = 32'h0;
        // reset mid-word, then fresh N=1 frame
        hdr(16'd2);
        word(32'hDEADBEEF, 8'd0);
        row(1, 8'h11, 1, 0, 1, 0, h_addr, h_data, 1, 0, 0);
        row(1, 8'h22, 0, 0, 1, 0, h_addr, h_data, 1, 0, 0);
        row(1, 8'h33, 0, 1, 1, 0, h_addr, h_data, 1, 0, 0);
        h_addr = 8'h00;
        h_data = 32'h0;
        hdr(16'd1);
        word(32'h00300F93, 8'd0);
        done_row(0, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            in_valid = vq[i].v;
            in_data  = vq[i].d;
            load_req = vq[i].lr;
            rst      = vq[i].rs;
            #1;
            check($sformatf("vec[%0d]", i),
                  {19'd0, in_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, done, err},
                  {19'd0, vq[i].exp});
        end
        @(negedge clk);
        in_valid = 1'b0;
        load_req = 1'b0;
        rst      = 1'b0;

        // N=3 with random gaps, in_valid held through WRITE
        ew.delete();
        ew.push_back(32'h00F00093);
        ew.push_back(32'h01900113);
        ew.push_back(32'h002081B3);
        build_frame();
        do_reset();
        wq_a.delete();
        wq_d.delete();
        stream(1'b1);
        compare_writes("gaps");

        // full depth N=256
        ew.delete();
        for (int k = 0; k < 256; k++) ew.push_back(32'h9E3779B9 * 32'(k + 1));
        build_frame();
        do_reset();
        wq_a.delete();
        wq_d.delete();
        stream(1'b0);
        compare_writes("full");
        repeat (3) @(negedge clk);
        check("full_no_extra", 64'(wq_a.size()), 64'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
